servo_pwm_decoder: RTL and testbench
====================================

// Module: servo_pwm_decoder
// PURPOSE
//  Receive-side counterpart of the servo PWM generator. Measures the high time and the
//  period of an incoming servo-style pulse train in prescaler ticks, then recovers the
//  3-bit speed/position code (high ticks = code+1). Sits between an external pin/loopback
//  and the display or control logic; flags malformed frames and signal loss.
// PARAMETERS
//  CLK_DIV      25000  clk cycles per measurement tick (2 kHz tick at 50 MHz)
//  PERIOD_TICKS 80     nominal frame period in ticks
//  PERIOD_TOL   2      accepted +/- deviation of measured period, ticks
//  CNT_W        8      width of tick counters and measured outputs
//  FILT_LEN     4      stable clk cycles required by glitch filter (optional feature only)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active high
//  pwm_in       in   1      asynchronous PWM input
//  code         out  3      last valid decoded code (high_ticks-1)
//  high_ticks   out  CNT_W  high time of last completed frame, ticks
//  period_ticks out  CNT_W  period of last completed frame, ticks
//  valid        out  1      one-clk strobe: frame completed, outputs updated
//  err          out  1      last completed frame out of spec (sticky until next frame)
//  lost         out  1      no edge for 2*PERIOD_TICKS ticks
// BEHAVIOUR
//  - Reset: code=0, high_ticks=0, period_ticks=0, valid=0, err=0, lost=0, FSM=IDLE, prescaler=0.
//  - pwm_in passes a 2-FF synchronizer; rise/fall detected on synchronized level vs prior.
//  - Prescaler counts 0..CLK_DIV-1, tick=1 for one clk at CLK_DIV-1, free-running after rst.
//  - FSM IDLE: ignore ticks; on rise -> HIGH, hi_cnt=0, per_cnt=0.
//  - HIGH: on tick hi_cnt++, per_cnt++; on fall -> LOW.
//  - LOW: on tick per_cnt++; on rise -> publish frame, clear both counters, -> HIGH.
//  - Same-clk tick and edge: tick counted in current state first, then transition.
//  - Counters saturate at 2^CNT_W-1, never wrap.
//  - Publish (1 clk): valid=1; high_ticks<=hi_cnt; period_ticks<=per_cnt;
//    err=1 if per_cnt outside PERIOD_TICKS+/-PERIOD_TOL or hi_cnt outside 1..8, else 0;
//    code<=hi_cnt-1 only when err=0, otherwise code holds; lost<=0.
//  - First rise after IDLE only starts measuring; first valid at the following rise.
//  - Timeout: in HIGH or LOW, per_cnt reaching 2*PERIOD_TICKS -> lost=1, FSM=IDLE,
//    counters cleared; other outputs hold. Covers stuck-high and stuck-low input.
//  - Latency: valid asserts 3 clk after pwm_in rise (2 sync + 1 register).
//  - Measurement quantized to ticks, +/-1 tick vs async input; tolerance absorbs it.
//  - rst mid-frame: all state and outputs return to reset values next clk; no valid emitted.
// CONFIGURATION
//  PWM_GLITCH_FILTER_EN defined: synchronized level must hold FILT_LEN consecutive clk
//    before filtered level changes; edges derive from filtered level; shorter pulses are
//    ignored; latency becomes 3+FILT_LEN clk. Filter state resets to 0.
//  Not defined: edges derive directly from synchronizer output, no filter logic built.
// TESTING (sim with CLK_DIV=4, tick-aligned stimulus)
//  1 rst held 3 clk mid-frame -> all outputs 0, no valid until two further rises.
//  2 frames high 4 ticks / period 80 -> valid each frame, code=3, high_ticks=4, period_ticks=80, err=0.
//  3 sweep high 1..8 ticks -> code 0..7; high 9 ticks -> err=1, code keeps prior value.
//  4 period 77 then 83 ticks -> err=1 both; period 78 -> err=0.
//  5 pwm_in stuck high 200 ticks -> lost=1 at per_cnt=160; next two good rises -> valid, lost=0.
//  6 PWM_GLITCH_FILTER_EN: 2-clk low glitch inside high pulse -> ignored, high_ticks unchanged;
//    without macro same stimulus -> extra edges, err=1.

Source files
------------

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures high time and period of a servo pulse train in ticks, recovers code = high_ticks-1.
// Latency: valid 3 clk after pwm_in rise (3+FILT_LEN with glitch filter); outputs hold between frames.
// Backpressure: none; valid is a one-clk strobe with no ready. Optional filter: define PWM_GLITCH_FILTER_EN.
module servo_pwm_decoder #(
  parameter int CLK_DIV      = 25000,
  parameter int PERIOD_TICKS = 80,
  parameter int PERIOD_TOL   = 2,
  parameter int CNT_W        = 8,
  parameter int FILT_LEN     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [2:0]       code,
  output logic [CNT_W-1:0] high_ticks,
  output logic [CNT_W-1:0] period_ticks,
  output logic             valid,
  output logic             err,
  output logic             lost
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0] PER_MIN = (CNT_W+1)'(PERIOD_TICKS - PERIOD_TOL);
  localparam logic [CNT_W:0] PER_MAX = (CNT_W+1)'(PERIOD_TICKS + PERIOD_TOL);
  localparam logic [CNT_W:0] HI_MAX  = (CNT_W+1)'(8);
  // If 2*PERIOD_TICKS does not fit the counter, time out at saturation instead.
  localparam int TO_INT = (2 * PERIOD_TICKS > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : 2 * PERIOD_TICKS;
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TO_INT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // Elaboration-time guard against parameter sets the datapath cannot represent.
  if (CLK_DIV < 1 || CNT_W < 4 || FILT_LEN < 1 || PERIOD_TOL < 0 || PERIOD_TICKS <= PERIOD_TOL) begin : g_bad_params
    $error("servo_pwm_decoder: invalid parameter set");
  end

  logic          sync1, sync2;
  logic          lvl, lvl_d;
  logic          rise, fall;
  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    state;
  logic [CNT_W-1:0] hi_cnt, per_cnt;
  logic [CNT_W-1:0] hi_inc, per_inc;
  logic          timeout;
  logic          frame_err;
  logic [2:0]    code_nxt;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  logic          filt_lvl;
  logic [FW-1:0] filt_cnt;

  // Filtered level follows the synchronizer only after FILT_LEN stable cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_lvl <= 1'b0;
      filt_cnt <= '0;
    end else if (sync2 == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_lvl <= sync2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = sync2;
`endif

  // Previous level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) lvl_d <= 1'b0;
    else     lvl_d <= lvl;
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  // Free-running measurement prescaler.
  always_ff @(posedge clk) begin
    if (rst)                 presc <= '0;
    else if (presc == PRE_LAST) presc <= '0;
    else                     presc <= presc + PW'(1);
  end

  assign tick = (presc == PRE_LAST);

  // Counter values including this cycle's tick, so a tick coincident with an edge lands in the old state.
  always_comb begin
    hi_inc  = hi_cnt;
    per_inc = per_cnt;
    if (tick && (state == ST_HIGH) && (hi_cnt != CNT_MAX))
      hi_inc = hi_cnt + CNT_W'(1);
    if (tick && ((state == ST_HIGH) || (state == ST_LOW)) && (per_cnt != CNT_MAX))
      per_inc = per_cnt + CNT_W'(1);
  end

  assign timeout   = (state != ST_IDLE) && ({1'b0, per_inc} >= TO_LIM);
  assign frame_err = ({1'b0, per_inc} < PER_MIN) || ({1'b0, per_inc} > PER_MAX) ||
                     (hi_inc == '0) || ({1'b0, hi_inc} > HI_MAX);
  // hi in 1..8 maps to 0..7; the low three bits minus one wrap 8 to 7.
  assign code_nxt  = hi_inc[2:0] - 3'd1;

  // Measurement FSM and published outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      hi_cnt       <= '0;
      per_cnt      <= '0;
      code         <= '0;
      high_ticks   <= '0;
      period_ticks <= '0;
      valid        <= 1'b0;
      err          <= 1'b0;
      lost         <= 1'b0;
    end else begin
      valid   <= 1'b0;
      hi_cnt  <= hi_inc;
      per_cnt <= per_inc;
      case (state)
        ST_IDLE: begin
          hi_cnt  <= '0;
          per_cnt <= '0;
          if (rise) state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (timeout) begin
            lost    <= 1'b1;
            state   <= ST_IDLE;
            hi_cnt  <= '0;
            per_cnt <= '0;
          end else if (fall) begin
            state <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (timeout) begin
            lost    <= 1'b1;
            state   <= ST_IDLE;
            hi_cnt  <= '0;
            per_cnt <= '0;
          end else if (rise) begin
            valid        <= 1'b1;
            high_ticks   <= hi_inc;
            period_ticks <= per_inc;
            err          <= frame_err;
            if (!frame_err) code <= code_nxt;
            lost         <= 1'b0;
            hi_cnt       <= '0;
            per_cnt      <= '0;
            state        <= ST_HIGH;
          end
        end
        default: begin
          state   <= ST_IDLE;
          hi_cnt  <= '0;
          per_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with CLK_DIV=4 and tick-multiple pulse widths.
// Each frame's results are checked after the following frame's rise has published them.
module tb_servo_pwm_decoder;
  localparam int DIV = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in;
  logic [2:0]    code;
  logic [CW-1:0] high_ticks;
  logic [CW-1:0] period_ticks;
  logic          valid;
  logic          err;
  logic          lost;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int vcnt    = 0;
  int exp_v   = 0;

  // Frame table: high ticks, period ticks, expected code, expected err.
  int fh[13] = '{4, 1, 2, 3, 5, 6, 7, 8, 9, 4, 4, 4, 4};
  int fp[13] = '{80, 80, 80, 80, 80, 80, 80, 80, 80, 77, 83, 78, 82};
  int fc[13] = '{3, 0, 1, 2, 4, 5, 6, 7, 7, 7, 7, 3, 3};
  int fe[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};

  servo_pwm_decoder #(
    .CLK_DIV(DIV), .PERIOD_TICKS(80), .PERIOD_TOL(2), .CNT_W(CW), .FILT_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .code(code), .high_ticks(high_ticks),
    .period_ticks(period_ticks), .valid(valid), .err(err), .lost(lost)
  );

  always #5 clk = ~clk;

  // Count valid strobes away from the active edge.
  always @(negedge clk) begin
    if (valid === 1'b1) vcnt++;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int h, input int p);
    pwm_in = 1'b1;
    clks(h * DIV);
    pwm_in = 1'b0;
    clks((p - h) * DIV);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int h, input int p, input int c, input int e);
    chk({tag, ".valid_count"}, vcnt, exp_v);
    chk({tag, ".high_ticks"}, 32'(high_ticks), h);
    chk({tag, ".period_ticks"}, 32'(period_ticks), p);
    chk({tag, ".code"}, 32'(code), c);
    chk({tag, ".err"}, 32'(err), e);
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    clks(3);
    chk("reset.code", 32'(code), 0);
    chk("reset.high_ticks", 32'(high_ticks), 0);
    chk("reset.period_ticks", 32'(period_ticks), 0);
    chk("reset.valid", 32'(valid), 0);
    chk("reset.err", 32'(err), 0);
    chk("reset.lost", 32'(lost), 0);
    rst = 1'b0;
    clks(2);

    // First rise only starts measuring.
    pulse(4, 80);
    chk("first_rise.valid_count", vcnt, 0);
    pulse(4, 80);
    exp_v = 1;
    check_frame("nominal1", 4, 80, 3, 0);

    // Reset in the low phase of a frame.
    pwm_in = 1'b1;
    clks(16);
    pwm_in = 1'b0;
    clks(40);
    exp_v = 2;
    chk("pre_rst.valid_count", vcnt, exp_v);
    rst = 1'b1;
    clks(3);
    chk("mid_rst.code", 32'(code), 0);
    chk("mid_rst.high_ticks", 32'(high_ticks), 0);
    chk("mid_rst.period_ticks", 32'(period_ticks), 0);
    chk("mid_rst.err", 32'(err), 0);
    chk("mid_rst.lost", 32'(lost), 0);
    rst = 1'b0;
    clks(100);
    pulse(4, 80);
    chk("post_rst_rise1.valid_count", vcnt, exp_v);
    chk("post_rst_rise1.code", 32'(code), 0);
    pulse(4, 80);
    exp_v++;
    check_frame("post_rst_rise2", 4, 80, 3, 0);

    // High-time sweep and period tolerance boundaries.
    for (int j = 1; j < 13; j++) begin
      pulse(fh[j], fp[j]);
      exp_v++;
      check_frame($sformatf("frame%0d", j - 1), fh[j-1], fp[j-1], fc[j-1], fe[j-1]);
    end

    // Stuck-high input: timeout at 160 ticks.
    pwm_in = 1'b1;
    clks(150 * DIV);
    exp_v++;
    check_frame("frame12", fh[12], fp[12], fc[12], fe[12]);
    chk("stuck150.lost", 32'(lost), 0);
    clks(20 * DIV);
    chk("stuck170.lost", 32'(lost), 1);
    chk("stuck170.code_hold", 32'(code), 3);
    chk("stuck170.high_hold", 32'(high_ticks), 4);
    clks(30 * DIV);
    pwm_in = 1'b0;
    clks(40 * DIV);
    pulse(4, 80);
    chk("recover_rise1.valid_count", vcnt, exp_v);
    chk("recover_rise1.lost", 32'(lost), 1);
    pulse(4, 80);
    exp_v++;
    check_frame("recover_rise2", 4, 80, 3, 0);
    chk("recover_rise2.lost", 32'(lost), 0);

    // Two-clock low glitch inside a 4-tick high pulse.
    pwm_in = 1'b1;
    clks(8);
    pwm_in = 1'b0;
    clks(2);
    pwm_in = 1'b1;
    clks(6);
    pwm_in = 1'b0;
    clks(320 - 16);
`ifdef PWM_GLITCH_FILTER_EN
    exp_v++;
    check_frame("glitch_prev", 4, 80, 3, 0);
    pulse(4, 80);
    exp_v++;
    check_frame("glitch_frame", 4, 80, 3, 0);
`else
    exp_v += 2;
    chk("glitch.valid_count", vcnt, exp_v);
    chk("glitch.err", 32'(err), 1);
    pulse(4, 80);
    exp_v++;
    chk("glitch_tail.valid_count", vcnt, exp_v);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
